calc_mem_ctrl: RTL

Controller for the calculator's memory register (M). It decodes the memory button pulses MC, MR, MS, M+ and M-, and owns the memory register and its status flags. M+ and M- are computed on the shared calculator ALU, so the block requests the ALU through a req/gnt handshake with the ALU arbiter, which also serves the execute path. MR produces a one-cycle recall pulse that the top-level FSM treats as a digit entry.

---
 rtl/calc_mem_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/calc_mem_ctrl.sv
// Calculator memory-register controller: decodes MC/MR/MS/M+/M-, owns M and its flags,
// and borrows the shared ALU through a req/gnt handshake for M+ and M-.
module calc_mem_ctrl #(
    parameter int           WIDTH   = 16,
    parameter int           TIMEOUT = 8,
    parameter logic [4:0]   CODE_MC = 5'b10001,
    parameter logic [4:0]   CODE_MR = 5'b10010,
    parameter logic [4:0]   CODE_MS = 5'b10011,
    parameter logic [4:0]   CODE_MP = 5'b10100,
    parameter logic [4:0]   CODE_MM = 5'b11000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       btn_pulse,
    input  logic [WIDTH-1:0] disp_val,
    input  logic             clr_all,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic             alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] recall_data,
    output logic             recall_valid,
    output logic             mem_nz,
    output logic             busy,
    output logic             cmd_drop,
    output logic             err,
    output logic [2:0]       state_led
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem, mem_nxt;
    logic [WIDTH-1:0] opnd, opnd_nxt;
    logic [WIDTH-1:0] rd_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             op_nxt, err_nxt, rv_nxt, drop_nxt, is_cmd;

    // Handshake: alu_req is high for every cycle spent in S_REQ; a cycle with
    // alu_req && alu_gnt is the transfer, and alu_result/alu_ovf are taken the cycle after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            mem          <= '0;
            opnd         <= '0;
            cnt          <= '0;
            alu_op       <= 1'b0;
            err          <= 1'b0;
            recall_data  <= '0;
            recall_valid <= 1'b0;
            cmd_drop     <= 1'b0;
            mem_nz       <= 1'b0;
        end else begin
            state        <= state_nxt;
            mem          <= mem_nxt;
            opnd         <= opnd_nxt;
            cnt          <= cnt_nxt;
            alu_op       <= op_nxt;
            err          <= err_nxt;
            recall_data  <= rd_nxt;
            recall_valid <= rv_nxt;
            cmd_drop     <= drop_nxt;
            mem_nz       <= (mem_nxt != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        mem_nxt   = mem;
        opnd_nxt  = opnd;
        cnt_nxt   = cnt;
        op_nxt    = alu_op;
        err_nxt   = err;
        rd_nxt    = recall_data;
        rv_nxt    = 1'b0;
        drop_nxt  = 1'b0;
        is_cmd    = (btn_pulse == CODE_MC) || (btn_pulse == CODE_MR) ||
                    (btn_pulse == CODE_MS) || (btn_pulse == CODE_MP) ||
                    (btn_pulse == CODE_MM);

        if (clr_all) begin
            // Aborts any in-flight M+/M- without writeback and swallows same-cycle commands.
            state_nxt = S_IDLE;
            mem_nxt   = '0;
            err_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            drop_nxt = is_cmd && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (btn_pulse == CODE_MC) begin
                        mem_nxt = '0;
                        err_nxt = 1'b0;
                    end else if (btn_pulse == CODE_MS) begin
                        mem_nxt = disp_val;
                    end else if (btn_pulse == CODE_MR) begin
                        rd_nxt = mem;
                        rv_nxt = 1'b1;
                    end else if ((btn_pulse == CODE_MP) || (btn_pulse == CODE_MM)) begin
                        opnd_nxt  = disp_val;
                        op_nxt    = (btn_pulse == CODE_MM);
                        cnt_nxt   = '0;
                        state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (alu_gnt) begin
                        state_nxt = S_WAIT;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (alu_ovf) err_nxt = 1'b1;
                    else         mem_nxt = alu_result;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_REQ:   state_led = 3'b010;
            S_WAIT:  state_led = 3'b100;
            default: state_led = 3'b001;
        endcase
    end

    assign alu_req = (state == S_REQ);
    assign busy    = (state != S_IDLE);
    assign alu_a   = mem;
    assign alu_b   = opnd;

endmodule
